// File: rtl/mips_ex_alu_dpath_pkg.sv
// rtl/mips_ex_alu_dpath_pkg.sv - shared widths, ALU opcodes, response ids and arbiter pointer type
package mips_ex_alu_dpath_pkg;

    localparam int MIPS_DATA_WIDTH = 32;
    localparam int MIPS_OPC_WIDTH  = 4;

    localparam logic [MIPS_OPC_WIDTH-1:0] MIPS_ALU_OPC_ADD  = 4'd0;
    localparam logic [MIPS_OPC_WIDTH-1:0] MIPS_ALU_OPC_SUB  = 4'd1;
    localparam logic [MIPS_OPC_WIDTH-1:0] MIPS_ALU_OPC_AND  = 4'd2;
    localparam logic [MIPS_OPC_WIDTH-1:0] MIPS_ALU_OPC_OR   = 4'd3;
    localparam logic [MIPS_OPC_WIDTH-1:0] MIPS_ALU_OPC_XOR  = 4'd4;
    localparam logic [MIPS_OPC_WIDTH-1:0] MIPS_ALU_OPC_NOR  = 4'd5;
    localparam logic [MIPS_OPC_WIDTH-1:0] MIPS_ALU_OPC_SLT  = 4'd6;
    localparam logic [MIPS_OPC_WIDTH-1:0] MIPS_ALU_OPC_SLTU = 4'd7;
    localparam logic [MIPS_OPC_WIDTH-1:0] MIPS_ALU_OPC_SLL  = 4'd8;
    localparam logic [MIPS_OPC_WIDTH-1:0] MIPS_ALU_OPC_SRL  = 4'd9;
    localparam logic [MIPS_OPC_WIDTH-1:0] MIPS_ALU_OPC_SRA  = 4'd10;
    localparam logic [MIPS_OPC_WIDTH-1:0] MIPS_ALU_OPC_LUI  = 4'd11;

    localparam logic MIPS_ALU_RSP_ID_ALU = 1'b0;
    localparam logic MIPS_ALU_RSP_ID_BJP = 1'b1;

    // Round-robin pointer: which client wins when both request together.
    typedef enum logic {
        RR_BJP = 1'b0,
        RR_ALU = 1'b1
    } rr_ptr_e;

endpackage

// File: rtl/mips_ex_alu_dpath_calc.sv
// rtl/mips_ex_alu_dpath_calc.sv - combinational ALU opcode and branch-compare evaluator
module mips_ex_alu_calc
    import mips_ex_alu_dpath_pkg::*;
#(
    parameter int DATA_WIDTH = MIPS_DATA_WIDTH,
    parameter int OPC_WIDTH  = MIPS_OPC_WIDTH
) (
    input  logic                  is_bjp,
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    input  logic [OPC_WIDTH-1:0]  opc,
    input  logic                  cmp_gez,
    input  logic                  cmp_ltz,
    input  logic                  cmp_eq,
    input  logic                  cmp_ne,
    input  logic                  cmp_lez,
    input  logic                  cmp_gtz,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  cmp_res
);

    logic [4:0] shamt;
    logic       op1_neg;
    logic       op1_zero;
    logic       ops_equal;

    assign shamt     = op1[4:0];
    assign op1_neg   = op1[DATA_WIDTH-1];
    assign op1_zero  = (op1 == '0);
    assign ops_equal = (op1 == op2);

    // Opcode evaluation for ALU clients; BJP always returns op1 - op2 and the ORed compare.
    always_comb begin
        result  = '0;
        cmp_res = 1'b0;
        if (is_bjp) begin
            result  = op1 - op2;
            cmp_res = (cmp_gez &  !op1_neg)
                    | (cmp_ltz &   op1_neg)
                    | (cmp_eq  &   ops_equal)
                    | (cmp_ne  &  !ops_equal)
                    | (cmp_lez &  (op1_neg || op1_zero))
                    | (cmp_gtz & !(op1_neg || op1_zero));
        end else begin
            case (opc)
                MIPS_ALU_OPC_ADD:  result = op1 + op2;
                MIPS_ALU_OPC_SUB:  result = op1 - op2;
                MIPS_ALU_OPC_AND:  result = op1 & op2;
                MIPS_ALU_OPC_OR:   result = op1 | op2;
                MIPS_ALU_OPC_XOR:  result = op1 ^ op2;
                MIPS_ALU_OPC_NOR:  result = ~(op1 | op2);
                MIPS_ALU_OPC_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
                MIPS_ALU_OPC_SLTU: result = {{(DATA_WIDTH-1){1'b0}}, (op1 < op2)};
                MIPS_ALU_OPC_SLL:  result = op2 << shamt;
                MIPS_ALU_OPC_SRL:  result = op2 >> shamt;
                MIPS_ALU_OPC_SRA:  result = $unsigned($signed(op2) >>> shamt);
                MIPS_ALU_OPC_LUI:  result = {op2[15:0], 16'b0};
                default:           result = '0;
            endcase
        end
    end

endmodule

// File: rtl/mips_ex_alu_dpath.sv
// rtl/mips_ex_alu_dpath.sv - shared EX ALU: round-robin arbiter plus one-entry response slot
module mips_ex_alu_dpath
    import mips_ex_alu_dpath_pkg::*;
#(
    parameter int DATA_WIDTH = MIPS_DATA_WIDTH,
    parameter int OPC_WIDTH  = MIPS_OPC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bjp_req_valid,
    output logic                  bjp_req_ready,
    input  logic [DATA_WIDTH-1:0] bjp_req_alu_op1,
    input  logic [DATA_WIDTH-1:0] bjp_req_alu_op2,
    input  logic                  bjp_req_alu_cmp_gez,
    input  logic                  bjp_req_alu_cmp_ltz,
    input  logic                  bjp_req_alu_cmp_eq,
    input  logic                  bjp_req_alu_cmp_ne,
    input  logic                  bjp_req_alu_cmp_lez,
    input  logic                  bjp_req_alu_cmp_gtz,
    input  logic                  alu_req_valid,
    output logic                  alu_req_ready,
    input  logic [DATA_WIDTH-1:0] alu_req_op1,
    input  logic [DATA_WIDTH-1:0] alu_req_op2,
    input  logic [OPC_WIDTH-1:0]  alu_req_opc,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_cmp_res
);

    rr_ptr_e               ptr_q,         ptr_d;
    logic                  rsp_valid_q,   rsp_valid_d;
    logic                  rsp_id_q,      rsp_id_d;
    logic [DATA_WIDTH-1:0] rsp_result_q,  rsp_result_d;
    logic                  rsp_cmp_res_q, rsp_cmp_res_d;

    logic                  accept;
    logic                  bjp_grant;
    logic                  alu_grant;
    logic [DATA_WIDTH-1:0] calc_op1;
    logic [DATA_WIDTH-1:0] calc_op2;
    logic [DATA_WIDTH-1:0] calc_result;
    logic                  calc_cmp_res;

    // The slot can take a new entry when empty or when it drains this same cycle.
    assign accept        = !rsp_valid_q || rsp_ready;
    assign bjp_req_ready = accept && (!alu_req_valid || ptr_q == RR_BJP);
    assign alu_req_ready = accept && (!bjp_req_valid || ptr_q == RR_ALU);
    assign bjp_grant     = bjp_req_valid && bjp_req_ready;
    assign alu_grant     = alu_req_valid && alu_req_ready;

    assign calc_op1 = bjp_grant ? bjp_req_alu_op1 : alu_req_op1;
    assign calc_op2 = bjp_grant ? bjp_req_alu_op2 : alu_req_op2;

    mips_ex_alu_calc #(
        .DATA_WIDTH (DATA_WIDTH),
        .OPC_WIDTH  (OPC_WIDTH)
    ) u_calc (
        .is_bjp  (bjp_grant),
        .op1     (calc_op1),
        .op2     (calc_op2),
        .opc     (alu_req_opc),
        .cmp_gez (bjp_req_alu_cmp_gez),
        .cmp_ltz (bjp_req_alu_cmp_ltz),
        .cmp_eq  (bjp_req_alu_cmp_eq),
        .cmp_ne  (bjp_req_alu_cmp_ne),
        .cmp_lez (bjp_req_alu_cmp_lez),
        .cmp_gtz (bjp_req_alu_cmp_gtz),
        .result  (calc_result),
        .cmp_res (calc_cmp_res)
    );

    // Next-state for pointer and response slot: reload on grant, clear on bare drain, else hold.
    always_comb begin
        ptr_d         = ptr_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_id_d      = rsp_id_q;
        rsp_result_d  = rsp_result_q;
        rsp_cmp_res_d = rsp_cmp_res_q;

        if (bjp_req_valid && alu_req_valid && (bjp_grant || alu_grant)) begin
            ptr_d = (ptr_q == RR_BJP) ? RR_ALU : RR_BJP;
        end

        if (bjp_grant || alu_grant) begin
            rsp_valid_d   = 1'b1;
            rsp_id_d      = bjp_grant ? MIPS_ALU_RSP_ID_BJP : MIPS_ALU_RSP_ID_ALU;
            rsp_result_d  = calc_result;
            rsp_cmp_res_d = calc_cmp_res;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // State registers; reset discards any pending response and restores BJP priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q         <= RR_BJP;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= MIPS_ALU_RSP_ID_ALU;
            rsp_result_q  <= '0;
            rsp_cmp_res_q <= 1'b0;
        end else begin
            ptr_q         <= ptr_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_result_q  <= rsp_result_d;
            rsp_cmp_res_q <= rsp_cmp_res_d;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_cmp_res = rsp_cmp_res_q;

endmodule

// File: tb/tb_mips_ex_alu_dpath.sv
// tb/tb_mips_ex_alu_dpath.sv - directed self-checking bench for mips_ex_alu_dpath
module tb_mips_ex_alu_dpath;

    logic        clk = 1'b0;
    logic        rst;
    logic        bjp_req_valid;
    logic        bjp_req_ready;
    logic [31:0] bjp_req_alu_op1;
    logic [31:0] bjp_req_alu_op2;
    logic        bjp_req_alu_cmp_gez;
    logic        bjp_req_alu_cmp_ltz;
    logic        bjp_req_alu_cmp_eq;
    logic        bjp_req_alu_cmp_ne;
    logic        bjp_req_alu_cmp_lez;
    logic        bjp_req_alu_cmp_gtz;
    logic        alu_req_valid;
    logic        alu_req_ready;
    logic [31:0] alu_req_op1;
    logic [31:0] alu_req_op2;
    logic [3:0]  alu_req_opc;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_cmp_res;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mips_ex_alu_dpath dut (
        .clk                 (clk),
        .rst                 (rst),
        .bjp_req_valid       (bjp_req_valid),
        .bjp_req_ready       (bjp_req_ready),
        .bjp_req_alu_op1     (bjp_req_alu_op1),
        .bjp_req_alu_op2     (bjp_req_alu_op2),
        .bjp_req_alu_cmp_gez (bjp_req_alu_cmp_gez),
        .bjp_req_alu_cmp_ltz (bjp_req_alu_cmp_ltz),
        .bjp_req_alu_cmp_eq  (bjp_req_alu_cmp_eq),
        .bjp_req_alu_cmp_ne  (bjp_req_alu_cmp_ne),
        .bjp_req_alu_cmp_lez (bjp_req_alu_cmp_lez),
        .bjp_req_alu_cmp_gtz (bjp_req_alu_cmp_gtz),
        .alu_req_valid       (alu_req_valid),
        .alu_req_ready       (alu_req_ready),
        .alu_req_op1         (alu_req_op1),
        .alu_req_op2         (alu_req_op2),
        .alu_req_opc         (alu_req_opc),
        .rsp_valid           (rsp_valid),
        .rsp_ready           (rsp_ready),
        .rsp_id              (rsp_id),
        .rsp_result          (rsp_result),
        .rsp_cmp_res         (rsp_cmp_res)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are read at +1 and +2.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // sel order: {gez, ltz, eq, ne, lez, gtz}
    task automatic set_bjp(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [5:0] sel);
        bjp_req_valid       = v;
        bjp_req_alu_op1     = a;
        bjp_req_alu_op2     = b;
        bjp_req_alu_cmp_gez = sel[5];
        bjp_req_alu_cmp_ltz = sel[4];
        bjp_req_alu_cmp_eq  = sel[3];
        bjp_req_alu_cmp_ne  = sel[2];
        bjp_req_alu_cmp_lez = sel[1];
        bjp_req_alu_cmp_gtz = sel[0];
    endtask

    task automatic set_alu(input logic v, input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b);
        alu_req_valid = v;
        alu_req_opc   = opc;
        alu_req_op1   = a;
        alu_req_op2   = b;
    endtask

    task automatic alu_op(input string tag, input logic [3:0] opc, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res);
        set_alu(1'b1, opc, a, b);
        #1;
        check({tag, "_ready"}, {31'd0, alu_req_ready}, 32'd1);
        tick();
        set_alu(1'b0, 4'd0, 32'd0, 32'd0);
        #1;
        check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        check({tag, "_id"}, {31'd0, rsp_id}, 32'd0);
        check({tag, "_result"}, rsp_result, exp_res);
        check({tag, "_cmp"}, {31'd0, rsp_cmp_res}, 32'd0);
    endtask

    task automatic bjp_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] sel, input logic [31:0] exp_res, input logic exp_cmp);
        set_bjp(1'b1, a, b, sel);
        #1;
        check({tag, "_ready"}, {31'd0, bjp_req_ready}, 32'd1);
        tick();
        set_bjp(1'b0, 32'd0, 32'd0, 6'd0);
        #1;
        check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        check({tag, "_id"}, {31'd0, rsp_id}, 32'd1);
        check({tag, "_result"}, rsp_result, exp_res);
        check({tag, "_cmp"}, {31'd0, rsp_cmp_res}, {31'd0, exp_cmp});
    endtask

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b0;
        set_bjp(1'b0, 32'd0, 32'd0, 6'd0);
        set_alu(1'b0, 4'd0, 32'd0, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_valid",  {31'd0, rsp_valid},   32'd0);
        check("rst_id",     {31'd0, rsp_id},      32'd0);
        check("rst_result", rsp_result,           32'd0);
        check("rst_cmp",    {31'd0, rsp_cmp_res}, 32'd0);

        rsp_ready = 1'b1;
        alu_op("add_ovf", 4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
        tick();
        check("drain_clear", {31'd0, rsp_valid}, 32'd0);

        alu_op("sub",  4'd1,  32'd5,          32'd7,          32'hFFFF_FFFE);
        alu_op("and",  4'd2,  32'hF0F0_FF00,  32'h0FF0_F0F0,  32'h00F0_F000);
        alu_op("or",   4'd3,  32'hF000_0001,  32'h0000_0F00,  32'hF000_0F01);
        alu_op("xor",  4'd4,  32'hFFFF_0000,  32'hFF00_FF00,  32'h00FF_FF00);
        alu_op("nor",  4'd5,  32'h0000_FFFF,  32'h00FF_0000,  32'hFF00_0000);
        alu_op("slt",  4'd6,  32'hFFFF_FFFF,  32'h0000_0001,  32'h0000_0001);
        alu_op("sltu", 4'd7,  32'h0000_0001,  32'hFFFF_FFFF,  32'h0000_0001);
        alu_op("sll",  4'd8,  32'h0000_0024,  32'h0000_0001,  32'h0000_0010);
        alu_op("srl",  4'd9,  32'h0000_0004,  32'h8000_0000,  32'h0800_0000);
        alu_op("sra",  4'd10, 32'h0000_0004,  32'h8000_0000,  32'hF800_0000);
        alu_op("lui",  4'd11, 32'h0000_0000,  32'hABCD_1234,  32'h1234_0000);
        alu_op("opc13",4'd13, 32'h0000_0003,  32'h0000_0004,  32'h0000_0000);

        bjp_op("beq",   32'h1234,     32'h1234, 6'b001000, 32'h0000_0000, 1'b1);
        bjp_op("bne",   32'h1234,     32'h1234, 6'b000100, 32'h0000_0000, 1'b0);
        bjp_op("bgtz",  32'h8000_0000, 32'd0,   6'b000001, 32'h8000_0000, 1'b0);
        bjp_op("blez",  32'd0,        32'd0,    6'b000010, 32'h0000_0000, 1'b1);
        bjp_op("bgez",  32'd5,        32'd3,    6'b100000, 32'h0000_0002, 1'b1);
        bjp_op("bltz",  32'hFFFF_FFFF, 32'd0,   6'b010000, 32'hFFFF_FFFF, 1'b1);
        bjp_op("nosel", 32'd5,        32'd5,    6'b000000, 32'h0000_0000, 1'b0);
        bjp_op("multi", 32'd5,        32'd1,    6'b110000, 32'h0000_0004, 1'b1);
        tick();

        // Contention: pointer has never moved, so BJP wins first, then alternation.
        set_bjp(1'b1, 32'd9, 32'd4, 6'b001000);
        set_alu(1'b1, 4'd0, 32'd1, 32'd2);
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("rr%0d_bjp_ready", i), {31'd0, bjp_req_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("rr%0d_alu_ready", i), {31'd0, alu_req_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
            tick();
            check($sformatf("rr%0d_id", i), {31'd0, rsp_id}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("rr%0d_result", i), rsp_result, (i % 2 == 0) ? 32'd5 : 32'd3);
        end

        // Backpressure: slot holds the ALU result, nothing is accepted.
        rsp_ready = 1'b0;
        #1;
        check("bp_bjp_ready", {31'd0, bjp_req_ready}, 32'd0);
        check("bp_alu_ready", {31'd0, alu_req_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("bp%0d_valid", i),  {31'd0, rsp_valid}, 32'd1);
            check($sformatf("bp%0d_id", i),     {31'd0, rsp_id},    32'd0);
            check($sformatf("bp%0d_result", i), rsp_result,         32'd3);
            check($sformatf("bp%0d_ready", i),  {30'd0, bjp_req_ready, alu_req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_bjp_ready", {31'd0, bjp_req_ready}, 32'd1);
        tick();
        check("reload_valid",  {31'd0, rsp_valid},   32'd1);
        check("reload_id",     {31'd0, rsp_id},      32'd1);
        check("reload_result", rsp_result,           32'd5);
        check("reload_cmp",    {31'd0, rsp_cmp_res}, 32'd0);

        // Reset with a full slot and the pointer favouring ALU.
        rsp_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_valid",     {31'd0, rsp_valid},     32'd0);
        check("post_rst_bjp_rdy",  {31'd0, bjp_req_ready}, 32'd1);
        check("post_rst_alu_rdy",  {31'd0, alu_req_ready}, 32'd0);
        tick();
        check("post_rst_id",       {31'd0, rsp_id},        32'd1);
        check("post_rst_valid",    {31'd0, rsp_valid},     32'd1);

        set_bjp(1'b0, 32'd0, 32'd0, 6'd0);
        set_alu(1'b0, 4'd0, 32'd0, 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
